// File: rtl/psum_buffer_pkg.sv
// Shared constants for the partial-sum row buffer: FSM encoding and size defaults.
package psum_buffer_pkg;
  localparam int PSUM_DATA_W = 16;
  localparam int OFM_SIZE    = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_ACCUM = 2'd2;
  localparam logic [1:0] ST_EMIT  = 2'd3;
endpackage

// File: rtl/psum_add.sv
// Signed partial-sum adder; PSUM_SAT_EN selects saturating add, otherwise wraps.
module psum_add #(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic signed [DATA_WIDTH-1:0] i_b,
  output logic signed [DATA_WIDTH-1:0] o_sum
);
`ifdef PSUM_SAT_EN
  logic signed [DATA_WIDTH:0] w_full;
  assign w_full = {i_a[DATA_WIDTH-1], i_a} + {i_b[DATA_WIDTH-1], i_b};

  // Top two bits disagree only when the result left the DATA_WIDTH range.
  always_comb begin
    o_sum = w_full[DATA_WIDTH-1:0];
    if (w_full[DATA_WIDTH] != w_full[DATA_WIDTH-1])
      o_sum = w_full[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
`else
  assign o_sum = i_a + i_b;
`endif
endmodule

// File: rtl/psum_buffer.sv
// Circular partial-sum row buffer: FILL stores, ACCUM adds head back in, EMIT sends to OFM.
// Build option: PSUM_SAT_EN makes the accumulate saturate instead of wrap.
module psum_buffer
  import psum_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = PSUM_DATA_W,
  parameter int DEPTH      = OFM_SIZE,
  parameter int CNT_W      = 4
) (
  input  logic                  clk2,
  input  logic                  rst,
  input  logic                  wr_en_psum,
  input  logic                  rd_en_psum,
  input  logic                  wr_clr,
  input  logic                  rd_clr,
  input  logic                  first_channel,
  input  logic                  last_channel,
  input  logic [DATA_WIDTH-1:0] psum_in,
  output logic [DATA_WIDTH-1:0] ofm_data,
  output logic                  ofm_valid,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output logic                  ovf_err,
  output logic                  udf_err
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_ofm_data;
  logic                  r_ofm_valid, r_ovf, r_udf;

  logic                  w_clr, w_wr, w_rd;
  logic [1:0]            w_chan, w_nxt, w_op;
  logic                  w_pop, w_udf, w_buf_wr, w_push, w_ovf, w_emit;
  logic [DATA_WIDTH-1:0] w_head, w_addend, w_sum, w_wdata;
  logic [PTR_W-1:0]      w_wr_inc, w_rd_inc, w_wr_n, w_rd_n;
  logic [CNT_W-1:0]      w_cnt_n;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

  // Clears win over enables in the same cycle.
  assign w_clr = wr_clr | rd_clr;
  assign w_wr  = wr_en_psum & ~w_clr;
  assign w_rd  = rd_en_psum & ~w_clr;

  assign w_chan = last_channel ? ST_EMIT : (first_channel ? ST_FILL : ST_ACCUM);

  always_comb begin
    w_nxt = r_state;
    if (wr_clr & rd_clr)        w_nxt = ST_IDLE;
    else if (r_state != ST_IDLE) w_nxt = w_chan;
    else if (w_wr)               w_nxt = w_chan;
  end

  // A write arriving in IDLE already acts as the pass it starts, so no write is lost.
  assign w_op = (r_state == ST_IDLE && w_wr) ? w_chan : r_state;

  assign w_head   = empty ? '0 : r_mem[r_rd_ptr];
  assign w_addend = (first_channel | ~w_rd) ? '0 : w_head;

  psum_add #(.DATA_WIDTH(DATA_WIDTH)) u_add (
    .i_a   (psum_in),
    .i_b   (w_addend),
    .o_sum (w_sum)
  );

  assign w_pop    = w_rd & ~empty & (w_op != ST_FILL);
  assign w_udf    = w_rd &  empty & (w_op != ST_FILL);
  assign w_buf_wr = w_wr & (w_op == ST_FILL || w_op == ST_ACCUM);
  assign w_push   = w_buf_wr & (~full | w_pop);
  assign w_ovf    = w_buf_wr & full & ~w_pop;
  assign w_emit   = w_wr & (w_op == ST_EMIT);
  assign w_wdata  = (w_op == ST_FILL) ? psum_in : w_sum;

  assign w_wr_inc = (r_wr_ptr == PTR_W'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_inc = (r_rd_ptr == PTR_W'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
  assign w_wr_n   = wr_clr ? '0 : (w_push ? w_wr_inc : r_wr_ptr);
  assign w_rd_n   = rd_clr ? '0 : (w_pop  ? w_rd_inc : r_rd_ptr);

  // A single clear re-derives occupancy from the surviving pointer distance.
  always_comb begin
    w_cnt_n = r_count;
    if (wr_clr & rd_clr)
      w_cnt_n = '0;
    else if (w_clr)
      w_cnt_n = (w_wr_n >= w_rd_n) ? CNT_W'(w_wr_n) - CNT_W'(w_rd_n)
                                   : CNT_W'(w_wr_n) + CNT_W'(DEPTH) - CNT_W'(w_rd_n);
    else if (w_push & ~w_pop)
      w_cnt_n = r_count + 1'b1;
    else if (w_pop & ~w_push)
      w_cnt_n = r_count - 1'b1;
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ofm_data  <= '0;
      r_ofm_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_wr_ptr    <= w_wr_n;
      r_rd_ptr    <= w_rd_n;
      r_count     <= w_cnt_n;
      r_ofm_valid <= w_emit;
      if (w_emit) r_ofm_data <= w_sum;
      if (w_ovf)  r_ovf <= 1'b1;
      if (w_udf)  r_udf <= 1'b1;
    end
  end

  always_ff @(posedge clk2) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wdata;
  end

  assign ofm_data  = r_ofm_data;
  assign ofm_valid = r_ofm_valid;
  assign count     = r_count;
  assign ovf_err   = r_ovf;
  assign udf_err   = r_udf;
endmodule

// File: tb/tb_psum_buffer.sv
// Directed bench for psum_buffer: fill, accumulate, emit, boundary errors, clears, saturation, reset.
module tb_psum_buffer;
  import psum_buffer_pkg::*;

  logic        clk2 = 1'b0;
  logic        rst, wr_en_psum, rd_en_psum, wr_clr, rd_clr, first_channel, last_channel;
  logic [15:0] psum_in, ofm_data;
  logic        ofm_valid, full, empty, ovf_err, udf_err;
  logic [3:0]  count;
  int          checks = 0;
  int          failures = 0;

  psum_buffer dut (
    .clk2(clk2), .rst(rst), .wr_en_psum(wr_en_psum), .rd_en_psum(rd_en_psum),
    .wr_clr(wr_clr), .rd_clr(rd_clr), .first_channel(first_channel),
    .last_channel(last_channel), .psum_in(psum_in), .ofm_data(ofm_data),
    .ofm_valid(ofm_valid), .full(full), .empty(empty), .count(count),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk2 = ~clk2;

  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] sat_exp;
`ifdef PSUM_SAT_EN
    sat_exp = 16'h7fff;
`else
    sat_exp = 16'h8000;
`endif
    rst = 1'b1; wr_en_psum = 1'b0; rd_en_psum = 1'b0; wr_clr = 1'b0; rd_clr = 1'b0;
    first_channel = 1'b0; last_channel = 1'b0; psum_in = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ofm_valid", ofm_valid, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_udf", udf_err, 0);
    chk("rst_state", dut.r_state, ST_IDLE);

    // FILL 1..7, then an 8th write into a full buffer
    first_channel = 1'b1;
    wr_en_psum = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      psum_in = 16'(i);
      step();
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 7);
    chk("fill_no_ovf", ovf_err, 0);
    psum_in = 16'd99;
    step();
    wr_en_psum = 1'b0;
    chk("fill_ovf", ovf_err, 1);
    chk("fill_ovf_count", count, 7);

    // ACCUM: +10 on every entry with simultaneous pop/push
    first_channel = 1'b0;
    step();
    wr_en_psum = 1'b1; rd_en_psum = 1'b1; psum_in = 16'd10;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("accum_count", count, 7);
    end
    wr_en_psum = 1'b0; rd_en_psum = 1'b0;

    // EMIT: +100, results 111..117 one cycle after each write
    last_channel = 1'b1;
    step();
    wr_en_psum = 1'b1; rd_en_psum = 1'b1; psum_in = 16'd100;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("emit_valid", ofm_valid, 1);
      chk("emit_data", ofm_data, 32'(111 + i));
    end
    wr_en_psum = 1'b0; rd_en_psum = 1'b0;
    step();
    chk("emit_valid_drop", ofm_valid, 0);
    chk("emit_empty", empty, 1);
    chk("emit_count", count, 0);

    // Pop on empty
    last_channel = 1'b0;
    step();
    rd_en_psum = 1'b1;
    step();
    rd_en_psum = 1'b0;
    chk("udf_flag", udf_err, 1);
    chk("udf_count", count, 0);
    chk("udf_wr_ptr", dut.r_wr_ptr, 0);
    chk("udf_rd_ptr", dut.r_rd_ptr, 0);

    // wr_clr beats a same-cycle write
    first_channel = 1'b1;
    step();
    wr_en_psum = 1'b1; psum_in = 16'd5;
    step();
    chk("pre_clr_count", count, 1);
    wr_clr = 1'b1; psum_in = 16'd9;
    step();
    wr_clr = 1'b0; wr_en_psum = 1'b0;
    chk("clr_wr_ptr", dut.r_wr_ptr, 0);
    chk("clr_count", count, 0);
    chk("clr_empty", empty, 1);
    chk("clr_ovf_sticky", ovf_err, 1);
    chk("clr_udf_sticky", udf_err, 1);

    // Saturation / wrap: head 32767 plus 1
    wr_clr = 1'b1; rd_clr = 1'b1;
    step();
    wr_clr = 1'b0; rd_clr = 1'b0;
    chk("dclr_state", dut.r_state, ST_IDLE);
    wr_en_psum = 1'b1; psum_in = 16'h7fff;
    step();
    wr_en_psum = 1'b0;
    chk("sat_prefill_count", count, 1);
    first_channel = 1'b0; last_channel = 1'b1;
    step();
    wr_en_psum = 1'b1; rd_en_psum = 1'b1; psum_in = 16'd1;
    step();
    wr_en_psum = 1'b0; rd_en_psum = 1'b0;
    chk("sat_valid", ofm_valid, 1);
    chk("sat_data", ofm_data, sat_exp);
    chk("sat_empty", empty, 1);

    // Reset mid-row
    last_channel = 1'b0; first_channel = 1'b1;
    step();
    wr_en_psum = 1'b1;
    for (int i = 0; i < 3; i++) begin
      psum_in = 16'(20 + i);
      step();
    end
    wr_en_psum = 1'b0;
    chk("midrow_count", count, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_state", dut.r_state, ST_IDLE);
    chk("midrst_ovf", ovf_err, 0);
    chk("midrst_udf", udf_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
